// File: rtl/router_out_arbiter.sv
// Round-robin scheduler merging three router output FIFOs onto one byte link.
// Holds the grant for a whole packet, checks parity on the fly, aborts on flush or stall.
module router_out_arbiter #(
    parameter int unsigned MAX_STALL = 30
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       vld_out_0,
    input  logic       vld_out_1,
    input  logic       vld_out_2,
    input  logic [7:0] data_out_0,
    input  logic [7:0] data_out_1,
    input  logic [7:0] data_out_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    output logic       read_enb_0,
    output logic       read_enb_1,
    output logic       read_enb_2,
    output logic [7:0] link_data,
    output logic       link_valid,
    input  logic       link_ready,
    output logic       link_sop,
    output logic       link_eop,
    output logic       parity_err,
    output logic       pkt_abort,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    localparam logic [7:0] STALL_LIMIT = 8'(MAX_STALL);

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] last_grant_q, last_grant_d;
    logic       first_q, first_d;
    logic [6:0] remaining_q, remaining_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] stall_q, stall_d;
    logic       parity_err_q, parity_err_d;
    logic       pkt_abort_q, pkt_abort_d;
    logic       busy_q, busy_d;

    logic [2:0] req_s;
    logic       g_vld_s, g_srst_s;
    logic [7:0] g_data_s;
    logic       xfer_s;
    logic [7:0] stall_inc_s;
    logic [1:0] pick_s, cand_s;
    logic       pick_ok_s;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        case (p)
            2'd0:    next_port = 2'd1;
            2'd1:    next_port = 2'd2;
            default: next_port = 2'd0;
        endcase
    endfunction

    assign req_s = {vld_out_2 & ~soft_reset_2, vld_out_1 & ~soft_reset_1, vld_out_0 & ~soft_reset_0};
    assign stall_inc_s = (stall_q == 8'hFF) ? stall_q : stall_q + 8'd1;

    assign parity_err = parity_err_q;
    assign pkt_abort  = pkt_abort_q;
    assign busy       = busy_q;

    // Select the granted FIFO's handshake and head byte
    always_comb begin
        case (grant_q)
            2'd0: begin
                g_vld_s  = vld_out_0;
                g_srst_s = soft_reset_0;
                g_data_s = data_out_0;
            end
            2'd1: begin
                g_vld_s  = vld_out_1;
                g_srst_s = soft_reset_1;
                g_data_s = data_out_1;
            end
            2'd2: begin
                g_vld_s  = vld_out_2;
                g_srst_s = soft_reset_2;
                g_data_s = data_out_2;
            end
            default: begin
                g_vld_s  = 1'b0;
                g_srst_s = 1'b0;
                g_data_s = 8'h00;
            end
        endcase
    end

    // Round-robin search starting just after the last granted port
    always_comb begin
        pick_s    = 2'd0;
        pick_ok_s = 1'b0;
        cand_s    = last_grant_q;
        for (int k = 0; k < 3; k++) begin
            cand_s = next_port(cand_s);
            if (!pick_ok_s && req_s[cand_s]) begin
                pick_s    = cand_s;
                pick_ok_s = 1'b1;
            end else begin
                pick_ok_s = pick_ok_s;
            end
        end
    end

    // Link side is a combinational pass-through of the granted FIFO
    always_comb begin
        if (state_q == ST_XFER) begin
            link_valid = g_vld_s & ~g_srst_s;
        end else begin
            link_valid = 1'b0;
        end
        link_data  = link_valid ? g_data_s : 8'h00;
        xfer_s     = link_valid & link_ready;
        link_sop   = link_valid & first_q;
        link_eop   = link_valid & ~first_q & (remaining_q == 7'd1);
        read_enb_0 = xfer_s & (grant_q == 2'd0);
        read_enb_1 = xfer_s & (grant_q == 2'd1);
        read_enb_2 = xfer_s & (grant_q == 2'd2);
    end

    // Next-state, packet tracking, parity and stall bookkeeping
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        first_d      = first_q;
        remaining_d  = remaining_q;
        acc_d        = acc_q;
        stall_d      = stall_q;
        parity_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_ok_s) begin
                    grant_d     = pick_s;
                    state_d     = ST_XFER;
                    first_d     = 1'b1;
                    remaining_d = 7'd0;
                    acc_d       = 8'h00;
                    stall_d     = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                // Abort outranks any transfer in the same cycle
                if (g_srst_s || (!g_vld_s && (stall_inc_s >= STALL_LIMIT))) begin
                    state_d      = ST_ABORT;
                    last_grant_d = grant_q;
                    first_d      = 1'b0;
                    remaining_d  = 7'd0;
                    acc_d        = 8'h00;
                    stall_d      = 8'd0;
                end else if (xfer_s) begin
                    stall_d = 8'd0;
                    if (first_q) begin
                        remaining_d = {1'b0, g_data_s[7:2]} + 7'd1;
                        acc_d       = g_data_s;
                        first_d     = 1'b0;
                    end else if (remaining_q == 7'd1) begin
                        parity_err_d = (g_data_s != acc_q);
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                        remaining_d  = 7'd0;
                        acc_d        = 8'h00;
                    end else begin
                        remaining_d = remaining_q - 7'd1;
                        acc_d       = acc_q ^ g_data_s;
                    end
                end else if (!g_vld_s) begin
                    stall_d = stall_inc_s;
                end else begin
                    stall_d = 8'd0;
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        pkt_abort_d = (state_d == ST_ABORT);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and registered status outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd2;
            first_q      <= 1'b0;
            remaining_q  <= 7'd0;
            acc_q        <= 8'h00;
            stall_q      <= 8'd0;
            parity_err_q <= 1'b0;
            pkt_abort_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            first_q      <= first_d;
            remaining_q  <= remaining_d;
            acc_q        <= acc_d;
            stall_q      <= stall_d;
            parity_err_q <= parity_err_d;
            pkt_abort_q  <= pkt_abort_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: tb/tb_router_out_arbiter.sv
// Bench for router_out_arbiter: FWFT FIFO models feed the DUT, a packet-level
// round-robin model predicts the byte stream, flags and parity-error pulses.
module tb_router_out_arbiter;
    localparam int MAX_STALL = 30;

    logic       clock = 1'b0;
    logic       resetn;
    logic [2:0] vld, srst, hold, rd;
    logic [7:0] dat [3];
    logic       link_ready;
    logic [7:0] link_data;
    logic       link_valid, link_sop, link_eop, parity_err, pkt_abort, busy;

    always #5 clock = ~clock;

    router_out_arbiter #(.MAX_STALL(MAX_STALL)) dut (
        .clock(clock), .resetn(resetn),
        .vld_out_0(vld[0]), .vld_out_1(vld[1]), .vld_out_2(vld[2]),
        .data_out_0(dat[0]), .data_out_1(dat[1]), .data_out_2(dat[2]),
        .soft_reset_0(srst[0]), .soft_reset_1(srst[1]), .soft_reset_2(srst[2]),
        .read_enb_0(rd[0]), .read_enb_1(rd[1]), .read_enb_2(rd[2]),
        .link_data(link_data), .link_valid(link_valid), .link_ready(link_ready),
        .link_sop(link_sop), .link_eop(link_eop), .parity_err(parity_err),
        .pkt_abort(pkt_abort), .busy(busy)
    );

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        logic [7:0] b;
        logic       sop;
        logic       eop;
        int         port;
        int         cyc;
        bit         corr;
    } rec_t;

    byte_q_t fq [3];
    byte_q_t eb [3];
    int      pl [3][$];
    bit      pc [3][$];
    rec_t    xq [$];
    rec_t    exq [$];
    int      pe_cyc [$];
    int      pa_cyc [$];
    int      cyc;
    bit      rd_bad, hold_bad;
    logic    prev_stall;
    logic [7:0] prev_data;
    logic    c_lv, c_sop, c_eop, c_pe, c_pa, c_bsy;
    logic [7:0] c_ld;
    logic [2:0] c_rd;
    int      errors = 0;
    int      checks = 0;

    task automatic cycle();
        int p;
        for (int i = 0; i < 3; i++) begin
            vld[i] = (fq[i].size() > 0) && !hold[i];
            dat[i] = vld[i] ? fq[i][0] : 8'h00;
        end
        #1;
        c_lv = link_valid; c_ld = link_data; c_sop = link_sop; c_eop = link_eop;
        c_pe = parity_err; c_pa = pkt_abort; c_bsy = busy; c_rd = rd;
        if ($countones(rd) > 1 || ((|rd) !== (link_valid & link_ready))) rd_bad = 1'b1;
        if (prev_stall && link_valid && (link_data !== prev_data)) hold_bad = 1'b1;
        prev_stall = link_valid & ~link_ready;
        prev_data  = link_data;
        if (link_valid && link_ready) begin
            p = rd[0] ? 0 : rd[1] ? 1 : rd[2] ? 2 : -1;
            xq.push_back('{link_data, link_sop, link_eop, p, cyc, 1'b0});
        end
        if (parity_err) pe_cyc.push_back(cyc);
        if (pkt_abort) pa_cyc.push_back(cyc);
        @(posedge clock);
        for (int i = 0; i < 3; i++) if (c_rd[i] && fq[i].size() > 0) fq[i].delete(0);
        @(negedge clock);
        cyc++;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 3; i++) begin
            fq[i].delete(); eb[i].delete(); pl[i].delete(); pc[i].delete();
        end
        xq.delete(); exq.delete(); pe_cyc.delete(); pa_cyc.delete();
        rd_bad = 1'b0; hold_bad = 1'b0; prev_stall = 1'b0; prev_data = 8'h00;
        srst = 3'b000; hold = 3'b000; link_ready = 1'b1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_all();
        cycle();
        cycle();
        resetn = 1'b1;
        cyc = 0;
    endtask

    // Push one well-formed (or deliberately corrupted) packet into FIFO and model
    task automatic add_pkt(input int port, input int len, input bit corrupt);
        logic [7:0] h, par, b;
        h   = {6'(len), 2'($urandom_range(0, 3))};
        par = h;
        fq[port].push_back(h); eb[port].push_back(h);
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom_range(0, 255));
            par = par ^ b;
            fq[port].push_back(b); eb[port].push_back(b);
        end
        if (corrupt) par = par ^ 8'(1 << $urandom_range(0, 7));
        fq[port].push_back(par); eb[port].push_back(par);
        pl[port].push_back(len);
        pc[port].push_back(corrupt);
    endtask

    // Expected byte stream: rotate over ports that still have packets queued
    task automatic build_exp(input int start_last);
        int last, p, n;
        bit cr;
        exq.delete();
        last = start_last;
        forever begin
            p = -1;
            for (int k = 1; k <= 3; k++)
                if (p < 0 && pl[(last + k) % 3].size() > 0) p = (last + k) % 3;
            if (p < 0) break;
            n  = pl[p].pop_front() + 2;
            cr = pc[p].pop_front();
            for (int j = 0; j < n; j++)
                exq.push_back('{eb[p].pop_front(), j == 0, j == n - 1, p, 0, cr});
            last = p;
        end
    endtask

    task automatic run_until(input int n, input int bound);
        int k = 0;
        while (xq.size() < n && k < bound) begin
            cycle();
            k++;
        end
    endtask

    task automatic test_reset();
        clear_all();
        resetn = 1'b0;
        for (int p = 0; p < 3; p++) add_pkt(p, 1, 1'b0);
        cycle();
        cycle();
        checks++; if (c_lv !== 1'b0) begin errors++; $display("FAIL reset_link_valid: got %b want 0", c_lv); end
        checks++; if (c_ld !== 8'h00) begin errors++; $display("FAIL reset_link_data: got %h want 00", c_ld); end
        checks++; if (c_rd !== 3'b000) begin errors++; $display("FAIL reset_read_enb: got %b want 000", c_rd); end
        checks++; if ({c_sop, c_eop} !== 2'b00) begin errors++; $display("FAIL reset_sop_eop: got %b want 00", {c_sop, c_eop}); end
        checks++; if ({c_pe, c_pa, c_bsy} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", {c_pe, c_pa, c_bsy}); end
        resetn = 1'b1;
        cyc = 0;
        build_exp(2);
        run_until(1, 10);
        checks++;
        if (xq.size() < 1 || xq[0].port != 0 || xq[0].sop !== 1'b1) begin
            errors++; $display("FAIL reset_first_grant: got port %0d want port 0 with sop", xq.size() > 0 ? xq[0].port : -1);
        end
    endtask

    task automatic test_single();
        logic [7:0] eb5 [5];
        int c0;
        eb5 = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
        do_reset();
        for (int i = 0; i < 5; i++) fq[0].push_back(eb5[i]);
        c0 = cyc;
        run_until(5, 20);
        cycle(); cycle(); cycle();
        checks++;
        if (xq.size() != 5) begin
            errors++; $display("FAIL single_count: got %0d bytes want 5", xq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (xq[i].b !== eb5[i] || xq[i].sop !== (i == 0) || xq[i].eop !== (i == 4) || xq[i].port != 0) begin
                    errors++; $display("FAIL single_byte%0d: got %h sop%b eop%b port%0d want %h", i, xq[i].b, xq[i].sop, xq[i].eop, xq[i].port, eb5[i]);
                end
            end
            checks++; if (xq[0].cyc != c0 + 1) begin errors++; $display("FAIL single_latency: first byte cycle %0d want %0d", xq[0].cyc, c0 + 1); end
            checks++; if (xq[4].cyc - xq[0].cyc != 4) begin errors++; $display("FAIL single_consecutive: span %0d want 4", xq[4].cyc - xq[0].cyc); end
        end
        checks++; if (pe_cyc.size() != 0) begin errors++; $display("FAIL single_parity_err: got %0d pulses want 0", pe_cyc.size()); end
        checks++; if (c_bsy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", c_bsy); end
        checks++; if (rd_bad) begin errors++; $display("FAIL single_read_enb: got inconsistent read_enb want one-hot pop per transfer"); end
    endtask

    task automatic test_round_robin();
        int bad;
        do_reset();
        add_pkt(0, 0, 1'b0); add_pkt(0, 0, 1'b0); add_pkt(1, 0, 1'b0); add_pkt(2, 0, 1'b0);
        build_exp(2);
        run_until(8, 40);
        bad = -1;
        if (xq.size() != exq.size()) bad = -2;
        else foreach (exq[i]) if (bad == -1 && (xq[i].b !== exq[i].b || xq[i].sop !== exq[i].sop || xq[i].eop !== exq[i].eop || xq[i].port != exq[i].port)) bad = i;
        checks++; if (bad != -1) begin errors++; $display("FAIL rr_stream: got %0d bytes want %0d, first bad index %0d", xq.size(), exq.size(), bad); end
        if (xq.size() == 8) begin
            checks++;
            if (xq[0].port != 0 || xq[2].port != 1 || xq[4].port != 2 || xq[6].port != 0) begin
                errors++; $display("FAIL rr_order: got %0d %0d %0d %0d want 0 1 2 0", xq[0].port, xq[2].port, xq[4].port, xq[6].port);
            end
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (xq[2 * k].cyc - xq[2 * k - 1].cyc != 2) begin
                    errors++; $display("FAIL rr_gap%0d: got %0d cycles want 2", k, xq[2 * k].cyc - xq[2 * k - 1].cyc);
                end
            end
        end
        checks++; if (rd_bad) begin errors++; $display("FAIL rr_read_enb: got overlapping or spurious read_enb want one-hot"); end
    endtask

    task automatic test_backpressure();
        int bad, k;
        do_reset();
        add_pkt(1, $urandom_range(2, 6), 1'b0);
        build_exp(2);
        k = 0;
        while (xq.size() < exq.size() && k < 120) begin
            link_ready = (k < 6) ? ((k % 2) == 0) : (k >= 41);
            cycle();
            k++;
        end
        link_ready = 1'b1;
        cycle(); cycle();
        bad = -1;
        if (xq.size() != exq.size()) bad = -2;
        else foreach (exq[i]) if (bad == -1 && (xq[i].b !== exq[i].b || xq[i].sop !== exq[i].sop || xq[i].eop !== exq[i].eop || xq[i].port != exq[i].port)) bad = i;
        checks++; if (bad != -1) begin errors++; $display("FAIL bp_stream: got %0d bytes want %0d, first bad index %0d", xq.size(), exq.size(), bad); end
        checks++; if (hold_bad) begin errors++; $display("FAIL bp_hold: got changing link_data while stalled want stable"); end
        checks++; if (pa_cyc.size() != 0) begin errors++; $display("FAIL bp_no_abort: got %0d aborts want 0", pa_cyc.size()); end
        checks++; if (rd_bad) begin errors++; $display("FAIL bp_read_enb: got pop without transfer want none"); end
    endtask

    task automatic test_parity();
        int bad;
        do_reset();
        add_pkt(2, 2, 1'b1);
        build_exp(2);
        run_until(4, 20);
        cycle(); cycle(); cycle();
        checks++;
        if (xq.size() != 4 || pe_cyc.size() != 1 || pe_cyc[0] != xq[3].cyc + 1) begin
            errors++; $display("FAIL parity_pulse: got %0d pulses first at %0d want 1 at eop+1", pe_cyc.size(), pe_cyc.size() > 0 ? pe_cyc[0] : -1);
        end
        xq.delete(); pe_cyc.delete();
        add_pkt(0, 1, 1'b0);
        build_exp(2);
        run_until(3, 20);
        cycle(); cycle();
        bad = -1;
        if (xq.size() != exq.size()) bad = -2;
        else foreach (exq[i]) if (bad == -1 && (xq[i].b !== exq[i].b || xq[i].sop !== exq[i].sop || xq[i].eop !== exq[i].eop || xq[i].port != exq[i].port)) bad = i;
        checks++; if (bad != -1) begin errors++; $display("FAIL parity_next_pkt: got %0d bytes want %0d, first bad index %0d", xq.size(), exq.size(), bad); end
        checks++; if (pe_cyc.size() != 0) begin errors++; $display("FAIL parity_next_clean: got %0d pulses want 0", pe_cyc.size()); end
    endtask

    task automatic test_abort_soft();
        int sc, bad;
        do_reset();
        add_pkt(1, 4, 1'b0);
        run_until(2, 10);
        add_pkt(0, 0, 1'b0);
        add_pkt(2, 0, 1'b0);
        srst[1] = 1'b1;
        sc = cyc;
        cycle();
        checks++; if (c_lv !== 1'b0 || c_rd !== 3'b000) begin errors++; $display("FAIL abort_quiet: got valid %b rd %b want 0 000", c_lv, c_rd); end
        srst[1] = 1'b0;
        fq[1].delete(); eb[1].delete(); pl[1].delete(); pc[1].delete();
        checks++; if (xq.size() != 2) begin errors++; $display("FAIL abort_partial: got %0d bytes want 2", xq.size()); end
        xq.delete();
        build_exp(1);
        run_until(4, 20);
        checks++; if (pa_cyc.size() != 1 || pa_cyc[0] != sc + 1) begin errors++; $display("FAIL abort_pulse: got %0d pulses first at %0d want 1 at %0d", pa_cyc.size(), pa_cyc.size() > 0 ? pa_cyc[0] : -1, sc + 1); end
        checks++; if (xq.size() < 1 || xq[0].port != 2 || xq[0].cyc != sc + 3) begin errors++; $display("FAIL abort_next_grant: got port %0d at %0d want port 2 at %0d", xq.size() > 0 ? xq[0].port : -1, xq.size() > 0 ? xq[0].cyc : -1, sc + 3); end
        bad = -1;
        if (xq.size() != exq.size()) bad = -2;
        else foreach (exq[i]) if (bad == -1 && (xq[i].b !== exq[i].b || xq[i].sop !== exq[i].sop || xq[i].eop !== exq[i].eop || xq[i].port != exq[i].port)) bad = i;
        checks++; if (bad != -1) begin errors++; $display("FAIL abort_after_stream: got %0d bytes want %0d, first bad index %0d", xq.size(), exq.size(), bad); end
    endtask

    task automatic test_stall();
        int hs, k;
        do_reset();
        add_pkt(0, 5, 1'b0);
        run_until(2, 10);
        hold[0] = 1'b1;
        hs = cyc;
        k = 0;
        while (pa_cyc.size() == 0 && k < 60) begin
            cycle();
            k++;
        end
        checks++;
        if (pa_cyc.size() == 0 || (pa_cyc[0] - hs) < MAX_STALL || (pa_cyc[0] - hs) > MAX_STALL + 1) begin
            errors++; $display("FAIL stall_abort: got abort after %0d empty cycles want %0d", pa_cyc.size() > 0 ? pa_cyc[0] - hs : -1, MAX_STALL);
        end
        checks++; if (xq.size() != 2) begin errors++; $display("FAIL stall_no_xfer: got %0d bytes want 2", xq.size()); end
        fq[0].delete();
        hold[0] = 1'b0;
        cycle(); cycle();
        checks++; if ({c_bsy, c_pa} !== 2'b00) begin errors++; $display("FAIL stall_idle_after: got busy/abort %b want 00", {c_bsy, c_pa}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        add_pkt(1, 8, 1'b0);
        run_until(3, 10);
        for (int i = 0; i < 3; i++) begin
            vld[i] = (fq[i].size() > 0);
            dat[i] = vld[i] ? fq[i][0] : 8'h00;
        end
        #1;
        resetn = 1'b0;
        #1;
        checks++; if ({link_valid, link_data, rd} !== 12'h000) begin errors++; $display("FAIL midreset_link: got valid %b data %h rd %b want all 0", link_valid, link_data, rd); end
        checks++; if ({link_sop, link_eop, parity_err, pkt_abort, busy} !== 5'b00000) begin errors++; $display("FAIL midreset_status: got %b want 00000", {link_sop, link_eop, parity_err, pkt_abort, busy}); end
        @(posedge clock);
        @(negedge clock);
        clear_all();
        add_pkt(1, 0, 1'b0); add_pkt(0, 0, 1'b0); add_pkt(2, 0, 1'b0);
        cycle(); cycle();
        resetn = 1'b1;
        xq.delete();
        build_exp(2);
        run_until(6, 30);
        checks++; if (xq.size() < 1 || xq[0].port != 0 || xq[0].sop !== 1'b1) begin errors++; $display("FAIL midreset_first_grant: got port %0d want 0", xq.size() > 0 ? xq[0].port : -1); end
    endtask

    task automatic test_random();
        int bad, k, ep [$];
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int p = 0; p < 3; p++)
                for (int n = 0; n < 2; n++) add_pkt(p, $urandom_range(0, 9), $urandom_range(0, 3) == 0);
            build_exp(2);
            k = 0;
            while (xq.size() < exq.size() && k < 3000) begin
                link_ready = ($urandom_range(0, 3) != 0);
                cycle();
                k++;
            end
            link_ready = 1'b1;
            cycle(); cycle(); cycle();
            bad = -1;
            if (xq.size() != exq.size()) bad = -2;
            else foreach (exq[i]) if (bad == -1 && (xq[i].b !== exq[i].b || xq[i].sop !== exq[i].sop || xq[i].eop !== exq[i].eop || xq[i].port != exq[i].port)) bad = i;
            checks++; if (bad != -1) begin errors++; $display("FAIL rand%0d_stream: got %0d bytes want %0d, first bad index %0d", it, xq.size(), exq.size(), bad); end
            ep.delete();
            foreach (exq[i]) if (exq[i].eop && exq[i].corr && i < xq.size()) ep.push_back(xq[i].cyc + 1);
            bad = (ep.size() == pe_cyc.size()) ? -1 : -2;
            foreach (ep[i]) if (bad == -1 && ep[i] != pe_cyc[i]) bad = i;
            checks++; if (bad != -1) begin errors++; $display("FAIL rand%0d_parity: got %0d pulses want %0d, first bad index %0d", it, pe_cyc.size(), ep.size(), bad); end
            checks++; if (rd_bad || hold_bad || pa_cyc.size() != 0) begin errors++; $display("FAIL rand%0d_handshake: got rd_bad %b hold_bad %b aborts %0d want 0 0 0", it, rd_bad, hold_bad, pa_cyc.size()); end
        end
    endtask

    initial begin
        resetn = 1'b0;
        srst = 3'b000; hold = 3'b000; vld = 3'b000; link_ready = 1'b1; cyc = 0;
        for (int i = 0; i < 3; i++) dat[i] = 8'h00;
        @(negedge clock);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_parity();
        test_abort_soft();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
